// File: rtl/wu_fetch_cntl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wu_fetch_cntl_pkg
//  Brief    : Shared types and constants for the WU instruction fetch block.
//  Revision : 1.0 - initial release
// ============================================================================
package wu_fetch_cntl_pkg;

    localparam int WUF_CREDITS = 4;
    localparam int WUF_MEM_LAT = 2;
    localparam int WUF_STATE_W = 2;
    localparam int WUF_CNT_W   = $clog2(WUF_CREDITS + 1);

    typedef enum logic [WUF_STATE_W-1:0] {
        WUF_STATE_IDLE  = 2'd0,
        WUF_STATE_FETCH = 2'd1,
        WUF_STATE_DRAIN = 2'd2
    } wuf_state_e;

    typedef struct packed {
        logic issued;
        logic stale;
    } wuf_tag_t;

    // A tag only produces a drop when it carries a real read that went stale.
    function automatic logic wuf_tag_drop(input wuf_tag_t tag);
        return tag.issued & tag.stale;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wu_fetch_cntl_if.sv
`default_nettype none
// ============================================================================
//  Module   : wu_fetch_cntl_if
//  Brief    : Start/memory/decoder/status signals of the WU fetch controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface wu_fetch_cntl_if #(
    parameter int ADDR_W = 12
);
    logic              sys__wuf__start;
    logic [ADDR_W-1:0] sys__wuf__start_addr;
    logic [ADDR_W-1:0] wuf__wum__addr;
    logic              wuf__wum__read;
    logic              wud__wuf__credit;
    logic              wud__wuf__jump_valid;
    logic [ADDR_W-1:0] wud__wuf__jump_addr;
    logic              wud__wuf__halt;
    logic              wuf__wud__drop;
    logic              wuf__sys__busy;
    logic              wuf__sys__done;

    // Fetch controller side.
    modport master (
        input  sys__wuf__start, sys__wuf__start_addr,
        input  wud__wuf__credit, wud__wuf__jump_valid, wud__wuf__jump_addr, wud__wuf__halt,
        output wuf__wum__addr, wuf__wum__read, wuf__wud__drop,
        output wuf__sys__busy, wuf__sys__done
    );

    // System / memory / decoder side.
    modport slave (
        output sys__wuf__start, sys__wuf__start_addr,
        output wud__wuf__credit, wud__wuf__jump_valid, wud__wuf__jump_addr, wud__wuf__halt,
        input  wuf__wum__addr, wuf__wum__read, wuf__wud__drop,
        input  wuf__sys__busy, wuf__sys__done
    );
endinterface
`default_nettype wire

// File: rtl/wu_fetch_cntl_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : wu_fetch_tag_pipe
//  Brief    : Tracks in-flight memory reads; flags entries made stale by a redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module wu_fetch_tag_pipe
    import wu_fetch_cntl_pkg::*;
#(
    parameter int MEM_LAT = WUF_MEM_LAT
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_issue,
    input  wire  i_flush,
    output logic o_drop,
    output logic o_auto_credit
);

    logic [MEM_LAT-1:0] r_issued;
    logic [MEM_LAT-1:0] r_stale;
    wuf_tag_t           w_head;

    // Stage 0 is fed by the registered read strobe, so the read presented to
    // memory in the redirect cycle is marked along with everything behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued <= '0;
            r_stale  <= '0;
        end else begin
            r_issued[0] <= i_issue;
            r_stale[0]  <= i_flush;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_issued[k] <= r_issued[k-1];
                r_stale[k]  <= r_stale[k-1] | i_flush;
            end
        end
    end

    assign w_head        = '{issued: r_issued[MEM_LAT-1], stale: r_stale[MEM_LAT-1]};
    assign o_drop        = wuf_tag_drop(w_head);
    assign o_auto_credit = wuf_tag_drop(w_head);

endmodule
`default_nettype wire

// File: rtl/wu_fetch_cntl.sv
`default_nettype none
// ============================================================================
//  Module   : wu_fetch_cntl
//  Brief    : Credit-limited WU instruction fetch sequencer with jump/halt redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module wu_fetch_cntl
    import wu_fetch_cntl_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int CREDITS = WUF_CREDITS,
    parameter int MEM_LAT = WUF_MEM_LAT
) (
    input  wire             clk,
    input  wire             reset_poweron,
    wu_fetch_cntl_if.master bus
);

    localparam int                 c_CNT_W       = $clog2(CREDITS + 1);
    localparam logic [c_CNT_W-1:0] c_CREDITS_MAX = c_CNT_W'(CREDITS);

    wuf_state_e          r_state;
    wuf_state_e          w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_read;
    logic                r_done;
    logic                w_issue;
    logic                w_flush;
    logic                w_done_nxt;
    logic                w_credit_eff;
    logic                w_auto_credit;
    logic                w_drop;
    logic [c_CNT_W-1:0]  r_in_flight;
    logic [c_CNT_W-1:0]  w_in_flight_nxt;

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            r_state     <= WUF_STATE_IDLE;
            r_pc        <= '0;
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_done      <= 1'b0;
            r_in_flight <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_read      <= w_issue;
            r_done      <= w_done_nxt;
            r_in_flight <= w_in_flight_nxt;
            if (w_issue) begin
                r_addr <= r_pc;
            end
        end
    end

    // Halt takes priority over jump; both suppress the issue slot of their cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            WUF_STATE_IDLE: begin
                if (bus.sys__wuf__start) begin
                    w_state_nxt = WUF_STATE_FETCH;
                    w_pc_nxt    = bus.sys__wuf__start_addr;
                end
            end
            WUF_STATE_FETCH: begin
                if (bus.wud__wuf__halt) begin
                    w_flush     = 1'b1;
                    w_state_nxt = WUF_STATE_DRAIN;
                end else if (bus.wud__wuf__jump_valid) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = bus.wud__wuf__jump_addr;
                end else if (r_in_flight < c_CREDITS_MAX) begin
                    w_issue  = 1'b1;
                    w_pc_nxt = r_pc + 1'b1;
                end
            end
            WUF_STATE_DRAIN: begin
                if (r_in_flight == '0) begin
                    w_state_nxt = WUF_STATE_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WUF_STATE_IDLE;
            end
        endcase
    end

    // A decoder credit with nothing outstanding is a protocol error and is ignored.
    assign w_credit_eff    = bus.wud__wuf__credit & (r_in_flight != '0);
    assign w_in_flight_nxt = r_in_flight + c_CNT_W'(w_issue)
                           - c_CNT_W'(w_credit_eff) - c_CNT_W'(w_auto_credit);

    wu_fetch_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk           (clk),
        .rst           (reset_poweron),
        .i_issue       (r_read),
        .i_flush       (w_flush),
        .o_drop        (w_drop),
        .o_auto_credit (w_auto_credit)
    );

    assign bus.wuf__wum__addr = r_addr;
    assign bus.wuf__wum__read = r_read;
    assign bus.wuf__wud__drop = w_drop;
    assign bus.wuf__sys__busy = (r_state != WUF_STATE_IDLE);
    assign bus.wuf__sys__done = r_done;

    a_no_credit_underflow : assert property (
        @(posedge clk) disable iff (reset_poweron)
        !(bus.wud__wuf__credit && (r_in_flight == '0))
    );

endmodule
`default_nettype wire

// File: tb/tb_wu_fetch_cntl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wu_fetch_cntl
//  Brief    : Directed bench with a transaction-level fetch model and memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wu_fetch_cntl;

    localparam int ADDR_W  = 12;
    localparam int CREDITS = 4;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic reset_poweron = 1'b1;
    always #5 clk = ~clk;

    wu_fetch_cntl_if #(.ADDR_W(ADDR_W)) bus();

    wu_fetch_cntl #(
        .ADDR_W  (ADDR_W),
        .CREDITS (CREDITS),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .bus           (bus)
    );

    // Stimulus, all driven at the falling edge.
    logic              s_start = 0, s_jump = 0, s_halt = 0, s_credit = 0;
    logic [ADDR_W-1:0] s_start_addr = '0, s_jump_addr = '0;
    bit                auto_cr = 0;
    assign bus.sys__wuf__start      = s_start;
    assign bus.sys__wuf__start_addr = s_start_addr;
    assign bus.wud__wuf__jump_valid = s_jump;
    assign bus.wud__wuf__jump_addr  = s_jump_addr;
    assign bus.wud__wuf__halt       = s_halt;
    assign bus.wud__wuf__credit     = s_credit;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: fixed latency, fed by whatever the DUT actually issues.
    logic              mem_p0_v = 0, mem_v = 0;
    logic [ADDR_W-1:0] mem_p0_a = '0, mem_a = '0;
    always @(posedge clk) begin
        mem_p0_v <= bus.wuf__wum__read;
        mem_p0_a <= bus.wuf__wum__addr;
        mem_v    <= mem_p0_v;
        mem_a    <= mem_p0_a;
    end

    // Behavioural model: outstanding reads as records with a delivery edge index.
    typedef struct { int deliver; int addr; bit stale; } rec_t;
    rec_t recs[$];
    int  cyc = 0, m_state = 0, m_pc = 0, m_inflight = 0, m_addr = 0, m_vis_addr = 0, rst_age = 0;
    bit  m_read = 0, m_done = 0, m_vis_valid = 0, m_vis_stale = 0;

    always @(posedge clk) begin : model
        bit issue, auto, cr;
        cyc++;
        issue = 0;
        if (reset_poweron) begin
            m_state = 0; m_pc = 0; m_inflight = 0; m_addr = 0; m_read = 0; m_done = 0;
            recs.delete();
            rst_age = 0;
        end else begin
            rst_age++;
            auto   = m_vis_valid && m_vis_stale;
            cr     = bus.wud__wuf__credit && (m_inflight > 0);
            m_done = 0;
            case (m_state)
                0: if (bus.sys__wuf__start) begin
                       m_state = 1;
                       m_pc    = int'(bus.sys__wuf__start_addr);
                   end
                1: if (bus.wud__wuf__halt || bus.wud__wuf__jump_valid) begin
                       // Anything not yet handed to the decoder before this edge is stale.
                       foreach (recs[i]) if (recs[i].deliver >= cyc) recs[i].stale = 1;
                       if (bus.wud__wuf__halt) m_state = 2;
                       else m_pc = int'(bus.wud__wuf__jump_addr);
                   end else if (m_inflight < CREDITS) begin
                       issue = 1;
                       recs.push_back('{deliver: cyc + MEM_LAT, addr: m_pc, stale: 0});
                       m_addr = m_pc;
                       m_pc   = (m_pc + 1) % (1 << ADDR_W);
                   end
                default: if (m_inflight == 0) begin
                       m_state = 0;
                       m_done  = 1;
                   end
            endcase
            m_read     = issue;
            m_inflight = m_inflight + int'(issue) - int'(cr) - int'(auto);
        end
        while (recs.size() > 0 && recs[0].deliver < cyc) void'(recs.pop_front());
        m_vis_valid = 0; m_vis_stale = 0; m_vis_addr = 0;
        if (recs.size() > 0 && recs[0].deliver == cyc) begin
            m_vis_valid = 1;
            m_vis_stale = recs[0].stale;
            m_vis_addr  = recs[0].addr;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("read",  bus.wuf__wum__read, m_read);
            if (m_read) chk("addr", bus.wuf__wum__addr, m_addr);
            chk("busy",  bus.wuf__sys__busy, m_state != 0);
            chk("done",  bus.wuf__sys__done, m_done);
            chk("drop",  bus.wuf__wud__drop, m_vis_valid && m_vis_stale);
            if (rst_age > MEM_LAT) begin
                chk("mem_valid", mem_v, m_vis_valid);
                if (m_vis_valid) chk("mem_data", mem_a, m_vis_addr);
            end
        end
    end

    // Per-cycle logs used by the literal expectations.
    logic [ADDR_W-1:0] rd_log[$];
    logic [ADDR_W-1:0] drop_log[$];
    int done_cnt = 0, tick_n = 0, rd_tick0 = -1, vld_tick0 = -1;

    task automatic clear_logs();
        rd_log.delete(); drop_log.delete();
        done_cnt = 0; rd_tick0 = -1; vld_tick0 = -1;
    endtask

    task automatic tick();
        @(negedge clk);
        tick_n++;
        if (bus.wuf__wum__read) begin
            rd_log.push_back(bus.wuf__wum__addr);
            if (rd_tick0 < 0) rd_tick0 = tick_n;
        end
        if (mem_v && vld_tick0 < 0) vld_tick0 = tick_n;
        if (mem_v && bus.wuf__wud__drop) drop_log.push_back(mem_a);
        if (bus.wuf__sys__done) done_cnt++;
        s_start = 0; s_jump = 0; s_halt = 0;
        s_credit = auto_cr && m_vis_valid && !m_vis_stale;
    endtask

    task automatic wait_read(input logic [ADDR_W-1:0] a, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = bus.wuf__wum__read && (bus.wuf__wum__addr == a);
        end
        chk(name, seen, 1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
        chk(name, done_cnt != 0, 1);
        repeat (3) tick();
        chk({name, "_once"}, done_cnt, 1);
        chk({name, "_idle"}, bus.wuf__sys__busy, 0);
    endtask

    task automatic do_reset();
        reset_poweron = 1;
        tick();
        reset_poweron = 0;
    endtask

    initial begin
        // Reset values
        repeat (2) tick();
        cmp_en = 1;
        tick();
        chk("rst_read", bus.wuf__wum__read, 0);
        chk("rst_addr", bus.wuf__wum__addr, 0);
        chk("rst_busy", bus.wuf__sys__busy, 0);
        chk("rst_done", bus.wuf__sys__done, 0);
        chk("rst_drop", bus.wuf__wud__drop, 0);
        reset_poweron = 0;

        // 1: streaming with a credit for every delivered entry
        clear_logs();
        auto_cr = 1;
        s_start = 1; s_start_addr = 12'h010;
        repeat (8) tick();
        chk("t1_rd0", rd_log[0], 12'h010);
        chk("t1_rd1", rd_log[1], 12'h011);
        chk("t1_rd2", rd_log[2], 12'h012);
        chk("t1_nreads", rd_log.size(), 7);
        chk("t1_lat", vld_tick0 - rd_tick0, MEM_LAT);
        chk("t1_nodrop", drop_log.size(), 0);
        s_halt = 1;
        wait_done("t1_done");

        // 2: credit window without any decoder credits
        clear_logs();
        auto_cr = 0;
        s_start = 1; s_start_addr = 12'h020;
        repeat (10) tick();
        chk("t2_nreads", rd_log.size(), 4);
        chk("t2_rd3", rd_log[3], 12'h023);
        s_credit = 1;
        repeat (5) tick();
        chk("t2_nreads_cr", rd_log.size(), 5);
        chk("t2_rd4", rd_log[4], 12'h024);
        do_reset();

        // 3: jump one cycle after the read of 0x031
        clear_logs();
        auto_cr = 1;
        s_start = 1; s_start_addr = 12'h02C;
        wait_read(12'h031, "t3_see_031");
        s_jump = 1; s_jump_addr = 12'h100;
        auto_cr = 0;
        rd_log.delete();
        repeat (12) tick();
        chk("t3_ndrop", drop_log.size(), 2);
        chk("t3_drop0", drop_log[0], 12'h030);
        chk("t3_drop1", drop_log[1], 12'h031);
        chk("t3_nreads", rd_log.size(), 4);
        chk("t3_rd0", rd_log[0], 12'h100);
        chk("t3_rd3", rd_log[3], 12'h103);
        do_reset();

        // 4: halt with one delivered and two piped entries
        clear_logs();
        auto_cr = 0;
        s_start = 1; s_start_addr = 12'h050;
        wait_read(12'h052, "t4_see_052");
        s_halt = 1;
        repeat (6) tick();
        chk("t4_busy", bus.wuf__sys__busy, 1);
        chk("t4_nodone", done_cnt, 0);
        chk("t4_ndrop", drop_log.size(), 2);
        chk("t4_drop0", drop_log[0], 12'h051);
        chk("t4_drop1", drop_log[1], 12'h052);
        chk("t4_nreads", rd_log.size(), 3);
        s_credit = 1;
        wait_done("t4_done");

        // 5: address wrap, second start ignored
        clear_logs();
        auto_cr = 1;
        s_start = 1; s_start_addr = 12'hFFE;
        repeat (2) tick();
        s_start = 1; s_start_addr = 12'h777;
        repeat (6) tick();
        chk("t5_rd0", rd_log[0], 12'hFFE);
        chk("t5_rd1", rd_log[1], 12'hFFF);
        chk("t5_rd2", rd_log[2], 12'h000);
        chk("t5_rd3", rd_log[3], 12'h001);
        s_halt = 1;
        wait_done("t5_done");

        // 6: reset with three reads in flight, then restart
        clear_logs();
        auto_cr = 0;
        s_start = 1; s_start_addr = 12'h060;
        wait_read(12'h062, "t6_see_062");
        reset_poweron = 1;
        tick();
        chk("t6_read", bus.wuf__wum__read, 0);
        chk("t6_busy", bus.wuf__sys__busy, 0);
        chk("t6_drop", bus.wuf__wud__drop, 0);
        reset_poweron = 0;
        rd_log.delete();
        s_start = 1; s_start_addr = 12'h040;
        repeat (10) tick();
        chk("t6_nreads", rd_log.size(), 4);
        chk("t6_rd0", rd_log[0], 12'h040);
        chk("t6_rd3", rd_log[3], 12'h043);
        do_reset();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
